// File: rtl/instr_encoder.sv
// MIPS instruction encoder/loader: packs one mnemonic plus its fields per handshake into
// a 32-bit instruction word and writes it to the next sequential imem location.
module instr_encoder #(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        mnem,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [15:0]       imm,
  input  logic [31:0]       target,
  input  logic              last,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [2:0] {S_IDLE, S_ENC, S_WR, S_DONE, S_ERR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [4:0]        r_mnem, r_rs, r_rt, r_rd;
  logic [15:0]       r_imm;
  logic [31:0]       r_target;
  logic              r_last;

  logic [31:0]        pc, pc4, br_diff, enc_word;
  logic signed [31:0] br_off;
  logic               br_in_range;
  logic [1:0]         enc_err;

  // Branch offset is word-relative to the delay-slot PC; it must fit the 16-bit field.
  always_comb begin
    pc          = BASE_ADDR + {{(30-ADDR_W){1'b0}}, wr_ptr, 2'b00};
    pc4         = pc + 32'd4;
    br_diff     = r_target - pc4;
    br_off      = $signed(br_diff) >>> 2;
    br_in_range = (&br_off[31:15]) | ~(|br_off[31:15]);
  end

  always_comb begin
    enc_word = 32'h0;
    enc_err  = 2'b00;
    case (r_mnem)
      5'd0:  enc_word = {6'h00, r_rs, r_rt, r_rd, 5'b0, 6'h21};
      5'd1:  enc_word = {6'h00, r_rs, r_rt, r_rd, 5'b0, 6'h23};
      5'd2:  enc_word = {6'h00, r_rs, r_rt, r_rd, 5'b0, 6'h20};
      5'd3:  enc_word = {6'h00, r_rs, r_rt, r_rd, 5'b0, 6'h24};
      5'd4:  enc_word = {6'h00, r_rs, r_rt, r_rd, 5'b0, 6'h25};
      5'd5:  enc_word = {6'h00, r_rs, r_rt, r_rd, 5'b0, 6'h2A};
      5'd6:  enc_word = {6'h00, r_rs, 15'b0, 6'h08};
      5'd7:  enc_word = {6'h08, r_rs, r_rt, r_imm};
      5'd8:  enc_word = {6'h09, r_rs, r_rt, r_imm};
      5'd9:  enc_word = {6'h0C, r_rs, r_rt, r_imm};
      5'd10: enc_word = {6'h0D, r_rs, r_rt, r_imm};
      5'd11: enc_word = {6'h0F, 5'b0, r_rt, r_imm};
      5'd12: enc_word = {6'h2B, r_rs, r_rt, r_imm};
      5'd13: enc_word = {6'h23, r_rs, r_rt, r_imm};
      5'd14, 5'd15: begin
        enc_word = {(r_mnem == 5'd14) ? 6'h02 : 6'h03, r_target[27:2]};
        if (r_target[1:0] != 2'b00 || r_target[31:28] != pc4[31:28]) enc_err = 2'b11;
      end
      5'd16: begin
        enc_word = {6'h04, r_rs, r_rt, br_off[15:0]};
        if (r_target[1:0] != 2'b00 || !br_in_range) enc_err = 2'b10;
      end
      5'd17:   enc_word = 32'h0;
      default: enc_err  = 2'b01;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      count    <= '0;
      im_wdata <= 32'h0;
      err_code <= 2'b00;
      r_mnem   <= '0;
      r_rs     <= '0;
      r_rt     <= '0;
      r_rd     <= '0;
      r_imm    <= '0;
      r_target <= '0;
      r_last   <= 1'b0;
    end else if (clr) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      count    <= '0;
      err_code <= 2'b00;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          r_mnem   <= mnem;
          r_rs     <= rs;
          r_rt     <= rt;
          r_rd     <= rd;
          r_imm    <= imm;
          r_target <= target;
          r_last   <= last;
          state    <= S_ENC;
        end
        S_ENC: begin
          if (enc_err != 2'b00) begin
            err_code <= enc_err;
            state    <= S_ERR;
          end else begin
            im_wdata <= enc_word;
            state    <= S_WR;
          end
        end
        S_WR: begin
          wr_ptr <= wr_ptr + ADDR_W'(1);
          count  <= count + (ADDR_W+1)'(1);
          state  <= (r_last || (&wr_ptr)) ? S_DONE : S_IDLE;
        end
        default: state <= state;
      endcase
    end
  end

  assign in_ready = (state == S_IDLE);
  assign im_we    = (state == S_WR);
  assign im_addr  = wr_ptr;
  assign busy     = (state == S_ENC) || (state == S_WR);
  assign done     = (state == S_DONE);
  assign err      = (state == S_ERR);

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a default-size instance for encoding/error/clr cases
// and a 4-word instance for capacity wrap and mid-operation reset.
module tb_instr_encoder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, clr = 1'b0, in_valid = 1'b0;
  logic        rst2 = 1'b1, clr2 = 1'b0, in_valid2 = 1'b0;
  logic [4:0]  mnem = '0, rs = '0, rt = '0, rd = '0;
  logic [15:0] imm = '0;
  logic [31:0] target = '0;
  logic        last = 1'b0;

  logic        in_ready, im_we, busy, done, err;
  logic [9:0]  im_addr;
  logic [31:0] im_wdata;
  logic [1:0]  err_code;
  logic [10:0] count;

  logic        in_ready2, im_we2, busy2, done2, err2;
  logic [1:0]  im_addr2;
  logic [31:0] im_wdata2;
  logic [1:0]  err_code2;
  logic [2:0]  count2;

  int n_checks = 0;
  int n_fail   = 0;

  instr_encoder #(.ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .mnem(mnem), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target), .last(last),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .busy(busy), .done(done),
    .err(err), .err_code(err_code), .count(count));

  instr_encoder #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst(rst2), .clr(clr2), .in_valid(in_valid2), .in_ready(in_ready2),
    .mnem(mnem), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target), .last(last),
    .im_we(im_we2), .im_addr(im_addr2), .im_wdata(im_wdata2), .busy(busy2), .done(done2),
    .err(err2), .err_code(err_code2), .count(count2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one instruction and returns at the negedge after acceptance (encoder in ENC).
  task automatic issue(input bit sel, input logic [4:0] m, input logic [4:0] s,
                       input logic [4:0] t, input logic [4:0] d, input logic [15:0] im,
                       input logic [31:0] tg, input logic lst);
    @(negedge clk);
    mnem = m; rs = s; rt = t; rd = d; imm = im; target = tg; last = lst;
    if (sel) in_valid2 = 1'b1; else in_valid = 1'b1;
    for (int i = 0; i < 10 && !(sel ? in_ready2 : in_ready); i++) @(negedge clk);
    chk("accept_ready", {31'b0, sel ? in_ready2 : in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0; in_valid2 = 1'b0;
  endtask

  task automatic check_write(input bit sel, input string tag, input logic [31:0] addr,
                             input logic [31:0] data);
    @(negedge clk);
    chk({tag, "_we"},   {31'b0, sel ? im_we2 : im_we}, 32'd1);
    chk({tag, "_addr"}, sel ? {30'b0, im_addr2} : {22'b0, im_addr}, addr);
    chk({tag, "_data"}, sel ? im_wdata2 : im_wdata, data);
    @(negedge clk);
    chk({tag, "_we_off"}, {31'b0, sel ? im_we2 : im_we}, 32'd0);
  endtask

  task automatic pulse_clr;
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_we",       {31'b0, im_we}, 32'd0);
    chk("rst_wdata",    im_wdata, 32'h0);
    chk("rst_done",     {31'b0, done}, 32'd0);
    chk("rst_err",      {31'b0, err}, 32'd0);
    chk("rst_err_code", {30'b0, err_code}, 32'd0);
    chk("rst_count",    {21'b0, count}, 32'd0);
    chk("rst_busy",     {31'b0, busy}, 32'd0);
    @(negedge clk); rst = 1'b0; rst2 = 1'b0;
    @(negedge clk);
    chk("rdy_after_rst", {31'b0, in_ready}, 32'd1);

    issue(0, 5'd0, 5'd1, 5'd2, 5'd3, 16'h0, 32'h0, 1'b0);
    chk("enc_busy",  {31'b0, busy}, 32'd1);
    chk("enc_ready", {31'b0, in_ready}, 32'd0);
    check_write(0, "addu", 32'd0, 32'h0022_1821);
    chk("addu_ready", {31'b0, in_ready}, 32'd1);
    chk("addu_count", {21'b0, count}, 32'd1);

    issue(0, 5'd10, 5'd0, 5'd8, 5'd0, 16'h1234, 32'h0, 1'b0);
    check_write(0, "ori", 32'd1, 32'h3408_1234);
    chk("ori_count", {21'b0, count}, 32'd2);

    issue(0, 5'd16, 5'd1, 5'd2, 5'd0, 16'h0, 32'h3000, 1'b0);
    check_write(0, "beq", 32'd2, 32'h1022_FFFD);

    issue(0, 5'd16, 5'd1, 5'd2, 5'd0, 16'h0, 32'h3002, 1'b0);
    @(negedge clk);
    chk("beq_bad_err",  {31'b0, err}, 32'd1);
    chk("beq_bad_code", {30'b0, err_code}, 32'd2);
    chk("beq_bad_we",   {31'b0, im_we}, 32'd0);
    @(negedge clk);
    chk("beq_bad_rdy",  {31'b0, in_ready}, 32'd0);
    chk("beq_bad_cnt",  {21'b0, count}, 32'd3);
    pulse_clr();
    chk("clr_err",   {31'b0, err}, 32'd0);
    chk("clr_count", {21'b0, count}, 32'd0);
    chk("clr_ready", {31'b0, in_ready}, 32'd1);

    issue(0, 5'd15, 5'd0, 5'd0, 5'd0, 16'h0, 32'h3010, 1'b0);
    check_write(0, "jal", 32'd0, 32'h0C00_0C04);
    issue(0, 5'd14, 5'd0, 5'd0, 5'd0, 16'h0, 32'h1000_0000, 1'b0);
    @(negedge clk);
    chk("j_bad_code", {30'b0, err_code}, 32'd3);
    pulse_clr();

    issue(0, 5'd20, 5'd0, 5'd0, 5'd0, 16'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("illegal_code", {30'b0, err_code}, 32'd1);
    pulse_clr();

    issue(0, 5'd13, 5'd0, 5'd9, 5'd0, 16'h0, 32'h0, 1'b1);
    check_write(0, "lw", 32'd0, 32'h8C09_0000);
    chk("lw_done",  {31'b0, done}, 32'd1);
    chk("lw_ready", {31'b0, in_ready}, 32'd0);
    chk("lw_count", {21'b0, count}, 32'd1);
    pulse_clr();
    chk("done_clr_count", {21'b0, count}, 32'd0);
    chk("done_clr_done",  {31'b0, done}, 32'd0);
    chk("done_clr_ready", {31'b0, in_ready}, 32'd1);

    issue(0, 5'd0, 5'd1, 5'd2, 5'd3, 16'h0, 32'h0, 1'b0);
    clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    chk("clr_enc_we",    {31'b0, im_we}, 32'd0);
    chk("clr_enc_ready", {31'b0, in_ready}, 32'd1);

    for (int k = 0; k < 4; k++) begin
      issue(1, 5'd17, 5'd0, 5'd0, 5'd0, 16'h0, 32'h0, 1'b0);
      check_write(1, "nop", k, 32'h0);
    end
    chk("wrap_done",  {31'b0, done2}, 32'd1);
    chk("wrap_count", {29'b0, count2}, 32'd4);
    @(negedge clk); clr2 = 1'b1;
    @(negedge clk); clr2 = 1'b0;
    issue(1, 5'd0, 5'd1, 5'd2, 5'd3, 16'h0, 32'h0, 1'b0);
    rst2 = 1'b1;
    #1;
    chk("rst_enc_busy",  {31'b0, busy2}, 32'd0);
    chk("rst_enc_wdata", im_wdata2, 32'h0);
    @(negedge clk);
    chk("rst_enc_we",    {31'b0, im_we2}, 32'd0);
    chk("rst_enc_count", {29'b0, count2}, 32'd0);
    chk("rst_enc_ready", {31'b0, in_ready2}, 32'd1);
    rst2 = 1'b0;
    @(negedge clk);
    chk("rst_enc_we2",   {31'b0, im_we2}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
